// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared state type and constants for the MIPS data-port bus bridge.
package mips_bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } bridge_state_t;

   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
   localparam logic [3:0]  BYTEEN_ALL       = 4'hF;

endpackage

// File: rtl/mips_data_bridge.sv
// mips_data_bridge: registers CPU loads/stores onto a waitrequest bus, stalls the CPU until done,
// and converts a hung slave into a sticky bus_error after a bounded number of wait cycles.
module mips_data_bridge
   import mips_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] cpu_address,
   input  logic        cpu_read,
   input  logic        cpu_write,
   input  logic [31:0] cpu_writedata,
   output logic [31:0] cpu_readdata,
   output logic        cpu_stall,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   output logic [3:0]  avm_byteenable,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        bus_error
);

   localparam int             CW       = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   bridge_state_t r_state;
   bridge_state_t w_next;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic [31:0]   r_rdata;
   logic          r_is_write;
   logic          r_err;
   logic [CW-1:0] r_cnt;
   logic          w_req;
   logic          w_complete;
   logic          w_timeout;
   logic          w_unused;

   assign w_req      = cpu_read | cpu_write;
   assign w_complete = (r_state == ACCESS) && !avm_waitrequest;
   assign w_timeout  = (r_state == ACCESS) && avm_waitrequest && (r_cnt == CNT_LAST);
   // Byte lanes are always all-on, so the low address bits carry no information.
   assign w_unused   = ^cpu_address[1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = IDLE;
      cpu_stall = 1'b0;
      avm_read  = 1'b0;
      avm_write = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_next    = w_req ? ACCESS : IDLE;
            cpu_stall = w_req;
         end
         ACCESS: begin
            w_next    = (w_complete || w_timeout) ? DONE : ACCESS;
            cpu_stall = 1'b1;
            avm_read  = !r_is_write;
            avm_write = r_is_write;
         end
         default: w_next = IDLE;
      endcase
   end

   // Write wins when both requests are present; the request is ignored outside IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_is_write <= 1'b0;
         r_err      <= 1'b0;
         r_cnt      <= '0;
      end else begin
         if (r_state == IDLE && w_req) begin
            r_addr     <= {cpu_address[31:2], 2'b00};
            r_wdata    <= cpu_writedata;
            r_is_write <= cpu_write;
            r_cnt      <= '0;
         end
         if (r_state == ACCESS && avm_waitrequest && r_cnt != CNT_LAST)
            r_cnt <= r_cnt + CW'(1);
         if (w_complete && !r_is_write)
            r_rdata <= avm_readdata;
         if (w_timeout) begin
            r_err <= 1'b1;
            if (!r_is_write) r_rdata <= ERR_DATA;
         end
      end
   end

   assign cpu_readdata   = r_rdata;
   assign avm_address    = r_addr;
   assign avm_writedata  = r_wdata;
   assign avm_byteenable = BYTEEN_ALL;
   assign bus_error      = r_err;

endmodule

// File: tb/tb_mips_data_bridge.sv
// tb_mips_data_bridge: randomized CPU/slave traffic checked every cycle against a transaction-level schedule model.
module tb_mips_data_bridge;

   localparam int          T    = 4;
   localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cpu_address, cpu_writedata, cpu_readdata;
   logic        cpu_read, cpu_write, cpu_stall;
   logic [31:0] avm_address, avm_writedata, avm_readdata;
   logic        avm_read, avm_write, avm_waitrequest, bus_error;
   logic [3:0]  avm_byteenable;

   int total = 0;
   int bad = 0;
   int n_stall = 0;
   int n_strobe = 0;
   int st, sb;

   logic        chk_en = 1'b0;
   logic        e_stall = 1'b0, e_rd = 1'b0, e_wr = 1'b0, e_acheck = 1'b0, e_err = 1'b0;
   logic [31:0] e_addr = '0, e_wdata = '0, e_rdata = '0;

   mips_data_bridge #(.TIMEOUT_CYCLES(T), .ERR_DATA(ERRV)) dut (
      .clk(clk), .reset(reset),
      .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
      .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata), .cpu_stall(cpu_stall),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
      .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest), .bus_error(bus_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("stall", {31'b0, cpu_stall}, {31'b0, e_stall});
         chk("avm_read", {31'b0, avm_read}, {31'b0, e_rd});
         chk("avm_write", {31'b0, avm_write}, {31'b0, e_wr});
         chk("byteen", {28'b0, avm_byteenable}, 32'hF);
         chk("readdata", cpu_readdata, e_rdata);
         chk("bus_error", {31'b0, bus_error}, {31'b0, e_err});
         if (e_acheck) begin
            chk("avm_address", avm_address, e_addr);
            if (e_wr) chk("avm_writedata", avm_writedata, e_wdata);
         end
         n_stall  = n_stall + int'(cpu_stall);
         n_strobe = n_strobe + int'(avm_read | avm_write);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      cpu_read = 1'b0; cpu_write = 1'b0;
      e_stall = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_acheck = 1'b0;
      repeat (n) begin
         cpu_address = $urandom; cpu_writedata = $urandom;
         avm_waitrequest = 1'($urandom); avm_readdata = $urandom;
         step();
      end
   endtask

   // One CPU access: request cycle, k bus cycles, commit cycle; k = waits+1 or T on abort.
   task automatic txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input int waits, input logic [31:0] rdv, output int stalls, output int strobes);
      logic re;
      bit   to;
      int   k;
      re = rd & ~wr;
      to = (waits >= T);
      k  = to ? T : waits + 1;
      n_stall = 0; n_strobe = 0;
      cpu_read = rd; cpu_write = wr; cpu_address = a; cpu_writedata = d;
      avm_waitrequest = 1'($urandom); avm_readdata = $urandom;
      e_stall = 1'b1; e_rd = 1'b0; e_wr = 1'b0; e_acheck = 1'b0;
      step();
      for (int j = 0; j < k; j++) begin
         e_stall = 1'b1; e_rd = re; e_wr = wr; e_acheck = 1'b1;
         e_addr = {a[31:2], 2'b00}; e_wdata = d;
         avm_waitrequest = (j < waits);
         avm_readdata = (j < waits) ? $urandom : rdv;
         cpu_address = $urandom; cpu_writedata = $urandom;
         step();
      end
      if (to) begin
         e_err = 1'b1;
         if (re) e_rdata = ERRV;
      end else if (re) e_rdata = rdv;
      e_stall = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_acheck = 1'b0;
      cpu_address = a; cpu_writedata = d;
      avm_waitrequest = 1'($urandom); avm_readdata = $urandom;
      step();
      stalls = n_stall; strobes = n_strobe;
      chk("stall_cycles", stalls, k + 1);
      chk("strobe_cycles", strobes, k);
   endtask

   initial begin
      reset = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = '0; cpu_writedata = '0;
      avm_readdata = '0; avm_waitrequest = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_stall", {31'b0, cpu_stall}, 32'h0);
      chk("rst_strobes", {30'b0, avm_read, avm_write}, 32'h0);
      chk("rst_addr", avm_address, 32'h0);
      chk("rst_wdata", avm_writedata, 32'h0);
      chk("rst_rdata", cpu_readdata, 32'h0);
      chk("rst_err", {31'b0, bus_error}, 32'h0);
      chk("rst_be", {28'b0, avm_byteenable}, 32'hF);
      reset = 1'b1;
      chk_en = 1'b1;
      idle(10);

      txn(1'b1, 1'b0, 32'h0000_1003, 32'h0, 0, 32'h1234_5678, st, sb);
      chk("zw_read_stall", st, 2);
      chk("zw_read_strobe", sb, 1);
      chk("zw_read_data", cpu_readdata, 32'h1234_5678);
      idle(1);

      txn(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 3, 32'h0, st, sb);
      chk("wt_write_stall", st, 5);
      chk("wt_write_strobe", sb, 4);
      chk("wt_write_keeps_rdata", cpu_readdata, 32'h1234_5678);
      idle(2);

      txn(1'b1, 1'b1, 32'h0000_0040, 32'h0BAD_F00D, 0, 32'h5555_AAAA, st, sb);
      chk("both_strobe", sb, 1);
      chk("both_keeps_rdata", cpu_readdata, 32'h1234_5678);
      idle(2);

      for (int i = 0; i < 30; i++) begin
         int op;
         op = $urandom_range(0, 2);
         txn(op != 1, op != 0, $urandom, $urandom, $urandom_range(0, T - 1), $urandom, st, sb);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      end
      chk("no_err_yet", {31'b0, bus_error}, 32'h0);

      txn(1'b1, 1'b0, 32'h0000_0300, 32'h0, 50, 32'h0, st, sb);
      chk("to_strobe", sb, 4);
      chk("to_stall", st, 5);
      chk("to_rdata", cpu_readdata, 32'hDEAD_BEEF);
      chk("to_err", {31'b0, bus_error}, 32'h1);
      txn(1'b1, 1'b0, 32'h0000_0304, 32'h0, 1, 32'h0000_0042, st, sb);
      chk("sticky_err", {31'b0, bus_error}, 32'h1);
      chk("after_to_rdata", cpu_readdata, 32'h0000_0042);

      for (int i = 0; i < 30; i++) begin
         int op;
         op = $urandom_range(0, 2);
         txn(op != 1, op != 0, $urandom, $urandom, $urandom_range(0, T + 2), $urandom, st, sb);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      end

      chk_en = 1'b0;
      cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = 32'h80; avm_waitrequest = 1'b1;
      step();
      step();
      chk("pre_rst_read", {31'b0, avm_read}, 32'h1);
      chk("pre_rst_stall", {31'b0, cpu_stall}, 32'h1);
      #2;
      reset = 1'b0; cpu_read = 1'b0;
      #1;
      chk("mid_rst_strobes", {30'b0, avm_read, avm_write}, 32'h0);
      chk("mid_rst_stall", {31'b0, cpu_stall}, 32'h0);
      chk("mid_rst_err", {31'b0, bus_error}, 32'h0);
      chk("mid_rst_rdata", cpu_readdata, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      e_rdata = '0; e_err = 1'b0;
      chk_en = 1'b1;
      idle(3);
      txn(1'b1, 1'b0, 32'h0000_0087, 32'h0, 2, 32'h7777_0001, st, sb);
      chk("post_rst_rdata", cpu_readdata, 32'h7777_0001);
      idle(2);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
